// File: rtl/ysyx_23060124_csr_exu.sv
// CSR / system-instruction execute unit: fixed 4-state sequence IDLE->READ->WRITE->RESP.
// Optional 64-bit cycle counter at 0xB00/0xB80 when YSYX_23060124_CSR_MCYCLE_EN is defined.
module ysyx_23060124_csr_exu #(
  parameter int unsigned XLEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_funct3,
  input  logic [11:0]         in_csr_addr,
  input  logic [4:0]          in_rs1_idx,
  input  logic [XLEN-1:0]     in_rs1_data,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                in_ecall,
  input  logic                in_mret,
  output logic [11:0]         csr_raddr,
  output logic [11:0]         csr_waddr,
  input  logic [XLEN-1:0]     csr_rdata,
  input  logic [XLEN-1:0]     csr_mepc,
  input  logic [XLEN-1:0]     csr_mtvec,
  output logic                csr_wen,
  output logic                csr_ecall,
  output logic                csr_mret,
  output logic [XLEN-1:0]     csr_wdata,
  output logic [XLEN-1:0]     csr_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_rd_data,
  output logic                out_redirect,
  output logic [XLEN-1:0]     out_redirect_pc
);

  localparam int unsigned AW = 12;
  localparam int unsigned FW = 3;
  localparam int unsigned IW = 5;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t state, next_state;

  logic [FW-1:0]   lat_funct3;
  logic [AW-1:0]   lat_addr;
  logic [IW-1:0]   lat_rs1_idx;
  logic [XLEN-1:0] lat_rs1_data;
  logic [XLEN-1:0] lat_pc;
  logic            lat_ecall;
  logic            lat_mret;
  logic [XLEN-1:0] old_q;

  logic            is_ecall, is_mret, is_csr, counter_hit, wen_c;
  logic [XLEN-1:0] read_val, operand, new_wdata;

  logic [AW-1:0]   n_raddr, n_waddr;
  logic            n_wen, n_ecall, n_mret, n_out_valid, n_redirect, n_in_ready;
  logic [XLEN-1:0] n_wdata, n_pc, n_rd_data, n_redirect_pc;

`ifdef YSYX_23060124_CSR_MCYCLE_EN
  logic [63:0] mcycle;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) mcycle <= '0;
    else       mcycle <= mcycle + 64'd1;
  end

  assign counter_hit = (lat_addr == 12'hB00) || (lat_addr == 12'hB80);
  assign read_val    = !counter_hit ? csr_rdata :
                       (lat_addr == 12'hB80) ? mcycle[63:32] : mcycle[31:0];
`else
  assign counter_hit = 1'b0;
  assign read_val    = csr_rdata;
`endif

  // Decode of the latched instruction; ecall dominates mret.
  assign is_ecall = lat_ecall;
  assign is_mret  = lat_mret && !lat_ecall;
  assign is_csr   = !lat_ecall && !lat_mret && (lat_funct3[1:0] != 2'b00);
  assign wen_c    = is_csr && !counter_hit &&
                    ((lat_funct3[1:0] == 2'b01) || (lat_rs1_idx != '0));
  assign operand  = lat_funct3[2] ? XLEN'(lat_rs1_idx) : lat_rs1_data;

  always_comb begin
    new_wdata = operand;
    case (lat_funct3[1:0])
      2'b10:   new_wdata = read_val | operand;
      2'b11:   new_wdata = read_val & ~operand;
      default: new_wdata = operand;
    endcase
  end

  // Instruction latches; old CSR value is captured at the end of READ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_funct3   <= '0;
      lat_addr     <= '0;
      lat_rs1_idx  <= '0;
      lat_rs1_data <= '0;
      lat_pc       <= '0;
      lat_ecall    <= 1'b0;
      lat_mret     <= 1'b0;
      old_q        <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        lat_funct3   <= in_funct3;
        lat_addr     <= in_csr_addr;
        lat_rs1_idx  <= in_rs1_idx;
        lat_rs1_data <= in_rs1_data;
        lat_pc       <= in_pc;
        lat_ecall    <= in_ecall;
        lat_mret     <= in_mret;
      end
      if (state == READ) old_q <= read_val;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state plus the value each registered output takes in that next state.
  always_comb begin
    next_state    = state;
    n_raddr       = '0;
    n_waddr       = '0;
    n_wen         = 1'b0;
    n_ecall       = 1'b0;
    n_mret        = 1'b0;
    n_wdata       = '0;
    n_pc          = '0;
    n_out_valid   = 1'b0;
    n_rd_data     = '0;
    n_redirect    = 1'b0;
    n_redirect_pc = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          next_state = READ;
          n_raddr    = in_csr_addr;
        end
      end
      READ: begin
        next_state = WRITE;
        n_wen      = wen_c;
        n_waddr    = wen_c ? lat_addr : '0;
        n_wdata    = wen_c ? new_wdata : '0;
        n_ecall    = is_ecall;
        n_mret     = is_mret;
        n_pc       = is_ecall ? lat_pc : '0;
      end
      WRITE: begin
        next_state    = RESP;
        n_out_valid   = 1'b1;
        n_rd_data     = is_csr ? old_q : '0;
        n_redirect    = is_ecall || is_mret;
        n_redirect_pc = is_ecall ? csr_mtvec : (is_mret ? csr_mepc : '0);
      end
      RESP: begin
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          n_out_valid   = 1'b1;
          n_rd_data     = out_rd_data;
          n_redirect    = out_redirect;
          n_redirect_pc = out_redirect_pc;
        end
      end
      default: next_state = IDLE;
    endcase
    n_in_ready = (next_state == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready        <= 1'b1;
      csr_raddr       <= '0;
      csr_waddr       <= '0;
      csr_wen         <= 1'b0;
      csr_ecall       <= 1'b0;
      csr_mret        <= 1'b0;
      csr_wdata       <= '0;
      csr_pc          <= '0;
      out_valid       <= 1'b0;
      out_rd_data     <= '0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
    end else begin
      in_ready        <= n_in_ready;
      csr_raddr       <= n_raddr;
      csr_waddr       <= n_waddr;
      csr_wen         <= n_wen;
      csr_ecall       <= n_ecall;
      csr_mret        <= n_mret;
      csr_wdata       <= n_wdata;
      csr_pc          <= n_pc;
      out_valid       <= n_out_valid;
      out_rd_data     <= n_rd_data;
      out_redirect    <= n_redirect;
      out_redirect_pc <= n_redirect_pc;
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_csr_exu.sv
// Directed bench for ysyx_23060124_csr_exu; define YSYX_23060124_CSR_MCYCLE_EN to cover the counter.
module tb_ysyx_23060124_csr_exu;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic [11:0] in_csr_addr;
  logic [4:0]  in_rs1_idx;
  logic [31:0] in_rs1_data, in_pc;
  logic        in_ecall, in_mret;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_mepc, csr_mtvec;
  logic        csr_wen, csr_ecall, csr_mret;
  logic [31:0] csr_wdata, csr_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_rd_data;
  logic        out_redirect;
  logic [31:0] out_redirect_pc;

  int errors = 0;
  int checks = 0;
  logic [63:0] cyc;

  always #5 clock = ~clock;

  // Reference count of clock edges since reset release.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 64'd1;
  end

  ysyx_23060124_csr_exu #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_csr_addr(in_csr_addr), .in_rs1_idx(in_rs1_idx),
    .in_rs1_data(in_rs1_data), .in_pc(in_pc), .in_ecall(in_ecall), .in_mret(in_mret),
    .csr_raddr(csr_raddr), .csr_waddr(csr_waddr), .csr_rdata(csr_rdata),
    .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec),
    .csr_wen(csr_wen), .csr_ecall(csr_ecall), .csr_mret(csr_mret),
    .csr_wdata(csr_wdata), .csr_pc(csr_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_data(out_rd_data),
    .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc)
  );

  // Offer one instruction and return #1 after the accepting edge (DUT in READ).
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                       input logic [31:0] data, input logic [31:0] pc,
                       input logic ec, input logic mr);
    in_valid = 1'b1; in_funct3 = f3; in_csr_addr = addr; in_rs1_idx = idx;
    in_rs1_data = data; in_pc = pc; in_ecall = ec; in_mret = mr;
    @(posedge clock); #1;
    in_valid = 1'b0; in_funct3 = 3'd0; in_csr_addr = 12'd0; in_rs1_idx = 5'd0;
    in_rs1_data = 32'd0; in_pc = 32'd0; in_ecall = 1'b0; in_mret = 1'b0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_funct3 = 3'd0; in_csr_addr = 12'd0; in_rs1_idx = 5'd0;
    in_rs1_data = 32'd0; in_pc = 32'd0; in_ecall = 1'b0; in_mret = 1'b0;
    csr_rdata = 32'd0; csr_mepc = 32'd0; csr_mtvec = 32'd0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    checks++;
    if ({out_valid, csr_wen, csr_ecall, csr_mret, out_redirect} !== 5'b0 ||
        out_rd_data !== 32'd0 || csr_raddr !== 12'd0 || csr_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_outputs valid=%0b wen=%0b rd=%h raddr=%h want all zero",
                         out_valid, csr_wen, out_rd_data, csr_raddr);
    end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_csrrw();
    issue(3'b001, 12'h305, 5'd5, 32'h80000100, 32'd0, 1'b0, 1'b0);
    csr_rdata = 32'd0;
    checks++;
    if (csr_raddr !== 12'h305 || in_ready !== 1'b0 || csr_wen !== 1'b0) begin
      errors++; $display("FAIL csrrw_read raddr=%h ready=%0b wen=%0b want 305/0/0", csr_raddr, in_ready, csr_wen);
    end
    step();
    checks++;
    if (csr_wen !== 1'b1 || csr_waddr !== 12'h305 || csr_wdata !== 32'h80000100 || csr_raddr !== 12'd0) begin
      errors++; $display("FAIL csrrw_write wen=%0b waddr=%h wdata=%h want 1/305/80000100", csr_wen, csr_waddr, csr_wdata);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_rd_data !== 32'd0 || out_redirect !== 1'b0 ||
        csr_wen !== 1'b0 || csr_waddr !== 12'd0 || csr_wdata !== 32'd0) begin
      errors++; $display("FAIL csrrw_resp valid=%0b rd=%h redir=%0b wen=%0b want 1/0/0/0", out_valid, out_rd_data, out_redirect, csr_wen);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL csrrw_idle ready=%0b valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_csrrs_nowen();
    issue(3'b010, 12'h300, 5'd0, 32'h0000FFFF, 32'd0, 1'b0, 1'b0);
    csr_rdata = 32'h00001800;
    step();
    checks++;
    if (csr_wen !== 1'b0) begin errors++; $display("FAIL csrrs_x0_wen got=%0b want=0", csr_wen); end
    csr_rdata = 32'd0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_rd_data !== 32'h00001800) begin
      errors++; $display("FAIL csrrs_rd valid=%0b rd=%h want 1/00001800", out_valid, out_rd_data);
    end
    step();
  endtask

  task automatic test_ecall();
    issue(3'b000, 12'h000, 5'd0, 32'd0, 32'h30000010, 1'b1, 1'b0);
    step();
    csr_mtvec = 32'h30000400;
    checks++;
    if (csr_ecall !== 1'b1 || csr_pc !== 32'h30000010 || csr_wen !== 1'b0 || csr_mret !== 1'b0) begin
      errors++; $display("FAIL ecall_write ecall=%0b pc=%h wen=%0b want 1/30000010/0", csr_ecall, csr_pc, csr_wen);
    end
    step();
    csr_mtvec = 32'd0;
    checks++;
    if (out_redirect !== 1'b1 || out_redirect_pc !== 32'h30000400 || out_rd_data !== 32'd0 ||
        csr_ecall !== 1'b0 || csr_pc !== 32'd0) begin
      errors++; $display("FAIL ecall_resp redir=%0b pc=%h rd=%h want 1/30000400/0", out_redirect, out_redirect_pc, out_rd_data);
    end
    step();
  endtask

  task automatic test_mret_stall();
    out_ready = 1'b0;
    issue(3'b000, 12'h000, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    csr_mepc = 32'h30000010;
    checks++;
    if (csr_mret !== 1'b1 || csr_ecall !== 1'b0 || csr_wen !== 1'b0) begin
      errors++; $display("FAIL mret_write mret=%0b ecall=%0b want 1/0", csr_mret, csr_ecall);
    end
    step();
    csr_mepc = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_redirect !== 1'b1 || out_redirect_pc !== 32'h30000010 ||
          out_rd_data !== 32'd0 || csr_mret !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL mret_hold_%0d valid=%0b redir=%0b pc=%h want 1/1/30000010", i, out_valid, out_redirect, out_redirect_pc);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_redirect !== 1'b0) begin
      errors++; $display("FAIL mret_release ready=%0b valid=%0b redir=%0b want 1/0/0", in_ready, out_valid, out_redirect);
    end
    csr_mepc = 32'd0;
  endtask

  task automatic test_both_flags();
    issue(3'b000, 12'h000, 5'd0, 32'd0, 32'h00000044, 1'b1, 1'b1);
    step();
    csr_mtvec = 32'h11110000; csr_mepc = 32'h22220000;
    checks++;
    if (csr_ecall !== 1'b1 || csr_mret !== 1'b0 || csr_pc !== 32'h00000044) begin
      errors++; $display("FAIL both_write ecall=%0b mret=%0b pc=%h want 1/0/00000044", csr_ecall, csr_mret, csr_pc);
    end
    step();
    csr_mtvec = 32'd0; csr_mepc = 32'd0;
    checks++;
    if (out_redirect !== 1'b1 || out_redirect_pc !== 32'h11110000) begin
      errors++; $display("FAIL both_resp redir=%0b pc=%h want 1/11110000", out_redirect, out_redirect_pc);
    end
    step();
  endtask

  task automatic test_noop();
    issue(3'b100, 12'h300, 5'd3, 32'h12345678, 32'd0, 1'b0, 1'b0);
    csr_rdata = 32'h00000055;
    step();
    checks++;
    if ({csr_wen, csr_ecall, csr_mret} !== 3'b000 || csr_wdata !== 32'd0) begin
      errors++; $display("FAIL noop_write strobes=%b wdata=%h want 000/0", {csr_wen, csr_ecall, csr_mret}, csr_wdata);
    end
    csr_rdata = 32'd0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_rd_data !== 32'd0 || out_redirect !== 1'b0) begin
      errors++; $display("FAIL noop_resp valid=%0b rd=%h redir=%0b want 1/0/0", out_valid, out_rd_data, out_redirect);
    end
    step();
  endtask

  task automatic test_csrrc_reset();
    issue(3'b111, 12'h300, 5'd8, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
    csr_rdata = 32'h00000088;
    step();
    checks++;
    if (csr_wen !== 1'b1 || csr_wdata !== 32'h00000080 || csr_waddr !== 12'h300) begin
      errors++; $display("FAIL csrrci_write wen=%0b wdata=%h waddr=%h want 1/00000080/300", csr_wen, csr_wdata, csr_waddr);
    end
    csr_rdata = 32'd0;
    step();
    checks++;
    if (out_rd_data !== 32'h00000088) begin errors++; $display("FAIL csrrci_rd got=%h want=00000088", out_rd_data); end
    step();
    issue(3'b001, 12'h341, 5'd7, 32'h00001234, 32'd0, 1'b0, 1'b0);
    step();
    checks++;
    if (csr_wen !== 1'b1 || csr_wdata !== 32'h00001234) begin
      errors++; $display("FAIL prereset_write wen=%0b wdata=%h want 1/00001234", csr_wen, csr_wdata);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (csr_wen !== 1'b0 || in_ready !== 1'b1 || csr_waddr !== 12'd0 || csr_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_in_write wen=%0b ready=%0b waddr=%h want 0/1/0", csr_wen, in_ready, csr_waddr);
    end
    @(negedge clock); reset = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL discard ready=%0b valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_counter_addr();
    logic [31:0] exp_lo;
    reset = 1'b1; #2; reset = 1'b0;
    @(negedge clock);
    while (cyc < 64'd99) @(posedge clock);
    #1;
    issue(3'b010, 12'hB00, 5'd5, 32'h0000000F, 32'd0, 1'b0, 1'b0);
    csr_rdata = 32'h0000DEAD;
`ifdef YSYX_23060124_CSR_MCYCLE_EN
    exp_lo = cyc[31:0];
`else
    exp_lo = 32'h0000DEAD;
`endif
    step();
    checks++;
`ifdef YSYX_23060124_CSR_MCYCLE_EN
    if (csr_wen !== 1'b0) begin errors++; $display("FAIL mcycle_wen got=%0b want=0", csr_wen); end
`else
    if (csr_wen !== 1'b1 || csr_waddr !== 12'hB00 || csr_wdata !== 32'h0000DEAF) begin
      errors++; $display("FAIL b00_fwd_write wen=%0b waddr=%h wdata=%h want 1/B00/0000DEAF", csr_wen, csr_waddr, csr_wdata);
    end
`endif
    csr_rdata = 32'd0;
    step();
    checks++;
    if (out_rd_data !== exp_lo) begin errors++; $display("FAIL b00_rd got=%h want=%h", out_rd_data, exp_lo); end
    step();
    issue(3'b010, 12'hB80, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    csr_rdata = 32'h0000BEEF;
    step();
    csr_rdata = 32'd0;
    step();
    checks++;
`ifdef YSYX_23060124_CSR_MCYCLE_EN
    if (out_rd_data !== 32'd0) begin errors++; $display("FAIL b80_rd got=%h want=00000000", out_rd_data); end
`else
    if (out_rd_data !== 32'h0000BEEF) begin errors++; $display("FAIL b80_rd got=%h want=0000BEEF", out_rd_data); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_csrrs_nowen();
    test_ecall();
    test_mret_stall();
    test_both_flags();
    test_noop();
    test_csrrc_reset();
    test_counter_addr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124_csr_exu.md
YSYX_23060124_CSR_EXU -- requirements
Module: ysyx_23060124_csr_exu

Interface
REQ-001 Parameter XLEN, default 32, data and PC width; only 32 is supported.
REQ-002 clock  in  1  single clock; all state updates on posedge clock.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_valid  in  1  upstream (IDU) offers a system instruction.
REQ-005 in_ready  out  1  block accepts; equals (state==IDLE).
REQ-006 in_funct3, in_csr_addr, in_rs1_idx  in  3/12/5  decoded fields; rs1_idx doubles as zimm.
REQ-007 in_rs1_data, in_pc  in  32/32  rs1 operand; instruction PC.
REQ-008 in_ecall, in_mret  in  1/1  decoded ecall and mret flags.
REQ-009 csr_raddr, csr_waddr  out  12/12  to the CSR register file.
REQ-010 csr_rdata, csr_mepc, csr_mtvec  in  32 each  from the CSR register file.
REQ-011 csr_wen, csr_ecall, csr_mret  out  1 each  single-cycle strobes to the CSR register file.
REQ-012 csr_wdata, csr_pc  out  32/32  write data; trapping PC.
REQ-013 out_valid  out  1  result available to WBU; out_ready  in  1  WBU accepts.
REQ-014 out_rd_data  out  32  old CSR value for rd; zero for ecall, mret and no-op.
REQ-015 out_redirect, out_redirect_pc  out  1/32  PC redirect for ecall or mret.

Function
REQ-016 FSM states: IDLE, READ, WRITE, RESP; IDLE->READ on in_valid&&in_ready, which latches all in_* fields; READ->WRITE, WRITE->RESP unconditionally; RESP->IDLE on out_valid&&out_ready.
REQ-017 Fixed latency: accept at T, csr strobes at T+2, out_valid first high at T+3; RESP holds all outputs stable until out_ready.
REQ-018 csr_raddr SHALL drive the latched address in READ; old value captured at end of READ.
REQ-019 funct3 001/010/011: wdata = rs1, old|rs1, old&~rs1; 101/110/111: the same with zimm zero-extended to 32 bits.
REQ-020 csr_wen SHALL pulse in WRITE for 001/101 always, and for 010/011/110/111 only when rs1_idx != 0.
REQ-021 Ecall: csr_ecall and csr_pc=latched pc in WRITE; csr_mtvec sampled that cycle into out_redirect_pc.
REQ-022 Mret: csr_mret in WRITE; csr_mepc sampled into out_redirect_pc.
REQ-023 in_ecall and in_mret both set: ecall wins, mret suppressed.
REQ-024 funct3 000 or 100 with neither flag: no strobes, rd_data 0, out_redirect 0.
REQ-025 out_redirect SHALL be high in RESP only for ecall or mret.
REQ-026 Outside WRITE, csr_wen, csr_ecall, csr_mret SHALL be 0; csr_waddr/csr_wdata 0 outside WRITE.

Reset
REQ-027 On reset: state IDLE, in_ready 1, every other output 0, all latches 0, regardless of prior state.
REQ-028 Reset asserted during WRITE SHALL drop the strobes in the same cycle; the instruction is discarded.

Configuration
REQ-029 Macro YSYX_23060124_CSR_MCYCLE_EN defined: 64-bit cycle counter, +1 per clock, reset 0, wraps at 2^64.
REQ-030 With it, reads of 0xB00/0xB80 return counter low/high captured in READ, and writes there are dropped (no csr_wen).
REQ-031 Without it, no counter exists; 0xB00/0xB80 are forwarded to the CSR register file like any other address.

Verification
REQ-032 csrrw 0x305, rs1=0x80000100, rs1_idx=5, old 0 -> wen at T+2, waddr 0x305, wdata 0x80000100, rd_data 0 at T+3.
REQ-033 csrrs 0x300, rs1_idx=0, old 0x1800 -> no csr_wen; rd_data 0x1800.
REQ-034 ecall, pc=0x30000010, mtvec=0x30000400 -> csr_ecall, csr_pc 0x30000010; redirect=1, redirect_pc 0x30000400.
REQ-035 mret, mepc=0x30000010; out_ready low 3 cycles -> outputs stable; redirect_pc 0x30000010; IDLE after handshake.
REQ-036 csrrc 0x300, zimm=8, old 0x88 -> wdata 0x80; then assert reset in WRITE of next csrrw -> strobes drop, in_ready 1.
REQ-037 With YSYX_23060124_CSR_MCYCLE_EN, csrrs rd 0xB00 at cycle 100 after reset -> rd_data equals counter at READ; no csr_wen.
